// File: rtl/qbus_slave_periph.sv
// rtl/qbus_slave_periph.sv - QBUS slave: word RAM, DL11-style consoles, vectored interrupts
module qbus_slave_periph #(
    parameter int          RAM_AW    = 13,
    parameter int          RPLY_WAIT = 0,
    parameter int          TTY_NUM   = 1,
    parameter logic [15:0] TTY_BASE  = 16'o177560,
    parameter logic [15:0] TTY_VEC   = 16'o000060,
    parameter int          TX_DELAY  = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sync_n,
    input  logic                   din_n,
    input  logic                   dout_n,
    input  logic                   wtbt_n,
    input  logic                   iako_n,
    input  logic [15:0]            ad_in_n,
    output logic [15:0]            ad_out_n,
    output logic                   ad_oe,
    output logic                   rply_n,
    output logic                   virq_n,
    input  logic [TTY_NUM-1:0]     rx_valid,
    input  logic [8*TTY_NUM-1:0]   rx_data,
    output logic [TTY_NUM-1:0]     tx_valid,
    output logic [8*TTY_NUM-1:0]   tx_data
);
    localparam int RAM_WORDS = 1 << RAM_AW;
    localparam int TCW       = $clog2(TX_DELAY + 1);

    typedef enum logic [1:0] {S_IDLE, S_ADR, S_WAIT, S_RPLY} state_t;

    state_t              state, state_nx;
    logic [15:0]         addr, wdata, rdata, rd_mux, tty_off, vec;
    logic [3:0]          wcnt;
    logic                is_wr, is_byte, is_iack;
    logic                sel_tty, sel_ram, strobe, iack_req, enter_rply, found;
    logic [1:0]          tty_ch, tty_reg;
    logic [RAM_AW-1:0]   widx;
    logic [15:0]         mem [RAM_WORDS];

    logic [TTY_NUM-1:0]  rx_done, rx_ie, tx_rdy, tx_ie;
    logic [TTY_NUM-1:0]  req_rx, req_tx, lvl_rx_q, lvl_tx_q, lvl_rx, lvl_tx;
    logic [TTY_NUM-1:0]  pick_rx, pick_tx, ack_rx, ack_tx, ch_wr, ch_rd;
    logic [7:0]          rbuf [TTY_NUM];
    logic [7:0]          tx_byte [TTY_NUM];
    logic [TCW-1:0]      tx_cnt [TTY_NUM];

    assign wdata      = ~ad_in_n;
    assign tty_off    = addr - TTY_BASE;
    assign sel_tty    = 32'(tty_off) < 32'(8 * TTY_NUM);
    assign sel_ram    = !sel_tty && (32'(addr) < 32'(2 * RAM_WORDS));
    assign tty_ch     = tty_off[4:3];
    assign tty_reg    = tty_off[2:1];
    assign widx       = addr[RAM_AW:1];
    assign strobe     = !din_n || !dout_n;
    assign iack_req   = sync_n && !din_n && !iako_n && (|req_rx || |req_tx);
    assign enter_rply = (state == S_WAIT) && (state_nx == S_RPLY);
    assign lvl_rx     = rx_done & rx_ie;
    assign lvl_tx     = tx_rdy & tx_ie;
    assign ack_rx     = pick_rx & {TTY_NUM{enter_rply && is_iack}};
    assign ack_tx     = pick_tx & {TTY_NUM{enter_rply && is_iack}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // An interrupt acknowledge runs with sync_n high, so only bus cycles abort on it.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (!sync_n) state_nx = S_ADR;
                    else if (iack_req) state_nx = S_WAIT;
            S_ADR:  if (sync_n) state_nx = S_IDLE;
                    else if ((sel_ram || sel_tty) && strobe) state_nx = S_WAIT;
            S_WAIT: if (sync_n && !is_iack) state_nx = S_IDLE;
                    else if (wcnt == 4'(RPLY_WAIT)) state_nx = S_RPLY;
            S_RPLY: if (sync_n && !is_iack) state_nx = S_IDLE;
                    else if (!strobe) state_nx = sync_n ? S_IDLE : S_ADR;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rply_n   = (state != S_RPLY);
        ad_oe    = (state == S_RPLY) && !is_wr;
        ad_out_n = ad_oe ? ~rdata : 16'hFFFF;
        virq_n   = !(|req_rx || |req_tx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr    <= '0;
            wcnt    <= '0;
            is_wr   <= 1'b0;
            is_byte <= 1'b0;
            is_iack <= 1'b0;
            rdata   <= '0;
        end else begin
            if (state == S_IDLE && !sync_n) addr <= ~ad_in_n;
            if (state_nx == S_WAIT && state != S_WAIT) begin
                wcnt    <= '0;
                is_iack <= (state == S_IDLE);
                is_wr   <= (state == S_ADR) && !dout_n;
                is_byte <= (state == S_ADR) && !dout_n && !wtbt_n;
            end else if (state == S_WAIT && wcnt != 4'(RPLY_WAIT)) begin
                wcnt <= wcnt + 4'd1;
            end
            if (enter_rply) rdata <= rd_mux;
        end
    end

    always_ff @(posedge clk) begin
        if (enter_rply && is_wr && !is_iack && sel_ram) begin
            if (!is_byte || !addr[0]) mem[widx][7:0]  <= wdata[7:0];
            if (!is_byte || addr[0])  mem[widx][15:8] <= wdata[15:8];
        end
    end

    always_comb begin
        rd_mux = '0;
        if (is_iack) rd_mux = vec;
        else if (sel_ram) rd_mux = mem[widx];
        else begin
            for (int n = 0; n < TTY_NUM; n++) begin
                if (tty_ch == 2'(n)) begin
                    case (tty_reg)
                        2'd0:    rd_mux = {8'd0, rx_done[n], rx_ie[n], 6'd0};
                        2'd1:    rd_mux = {8'd0, rbuf[n]};
                        2'd2:    rd_mux = {8'd0, tx_rdy[n], tx_ie[n], 6'd0};
                        default: rd_mux = '0;
                    endcase
                end
            end
        end
    end

    // Lowest channel wins; within a channel the receiver beats the transmitter.
    always_comb begin
        pick_rx = '0;
        pick_tx = '0;
        vec     = '0;
        found   = 1'b0;
        for (int n = 0; n < TTY_NUM; n++) begin
            if (!found && req_rx[n]) begin
                pick_rx[n] = 1'b1;
                vec        = TTY_VEC + 16'(8 * n);
                found      = 1'b1;
            end else if (!found && req_tx[n]) begin
                pick_tx[n] = 1'b1;
                vec        = TTY_VEC + 16'(8 * n + 4);
                found      = 1'b1;
            end
        end
    end

    // Registers live in the low byte, so a byte write to the odd half is dropped.
    always_comb begin
        ch_wr = '0;
        ch_rd = '0;
        for (int n = 0; n < TTY_NUM; n++) begin
            if (enter_rply && !is_iack && sel_tty && tty_ch == 2'(n)) begin
                ch_wr[n] = is_wr && !(is_byte && addr[0]);
                ch_rd[n] = !is_wr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_done  <= '0;
            rx_ie    <= '0;
            tx_rdy   <= '1;
            tx_ie    <= '0;
            req_rx   <= '0;
            req_tx   <= '0;
            lvl_rx_q <= '0;
            lvl_tx_q <= '0;
            tx_valid <= '0;
            for (int n = 0; n < TTY_NUM; n++) begin
                rbuf[n]    <= '0;
                tx_byte[n] <= '0;
                tx_cnt[n]  <= '0;
            end
        end else begin
            tx_valid <= '0;
            lvl_rx_q <= lvl_rx;
            lvl_tx_q <= lvl_tx;
            for (int n = 0; n < TTY_NUM; n++) begin
                if (ch_wr[n] && tty_reg == 2'd0) rx_ie[n] <= wdata[6];
                if (ch_wr[n] && tty_reg == 2'd2) tx_ie[n] <= wdata[6];
                if (ch_rd[n] && tty_reg == 2'd1) rx_done[n] <= 1'b0;
                if (rx_valid[n]) begin
                    rx_done[n] <= 1'b1;
                    rbuf[n]    <= rx_data[8*n +: 8];
                end
                if (ch_wr[n] && tty_reg == 2'd3) begin
                    tx_byte[n]  <= wdata[7:0];
                    tx_valid[n] <= 1'b1;
                    tx_rdy[n]   <= 1'b0;
                    tx_cnt[n]   <= TCW'(TX_DELAY - 1);
                end else if (!tx_rdy[n]) begin
                    if (tx_cnt[n] == '0) tx_rdy[n] <= 1'b1;
                    else                 tx_cnt[n] <= tx_cnt[n] - 1'b1;
                end
                if (!rx_ie[n])                        req_rx[n] <= 1'b0;
                else if (lvl_rx[n] && !lvl_rx_q[n])   req_rx[n] <= 1'b1;
                else if (ack_rx[n])                   req_rx[n] <= 1'b0;
                if (!tx_ie[n])                        req_tx[n] <= 1'b0;
                else if (lvl_tx[n] && !lvl_tx_q[n])   req_tx[n] <= 1'b1;
                else if (ack_tx[n])                   req_tx[n] <= 1'b0;
            end
        end
    end

    always_comb begin
        tx_data = '0;
        for (int n = 0; n < TTY_NUM; n++) tx_data[8*n +: 8] = tx_byte[n];
    end
endmodule

// File: tb/tb_qbus_slave_periph.sv
// tb/tb_qbus_slave_periph.sv - directed bench for qbus_slave_periph
module tb_qbus_slave_periph;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sync_n = 1'b1, din_n = 1'b1, dout_n = 1'b1, wtbt_n = 1'b1, iako_n = 1'b1;
    logic        sync3_n = 1'b1, din3_n = 1'b1;
    logic [15:0] ad_in_n = 16'hFFFF;
    logic [15:0] ad_out_n, ad3_out_n;
    logic        ad_oe, ad3_oe, rply_n, rply3_n, virq_n, virq3_n;
    logic [1:0]  rx_valid = 2'b00;
    logic [15:0] rx_data = 16'h0000;
    logic [1:0]  tx_valid;
    logic [15:0] tx_data;
    logic [0:0]  tx3_valid;
    logic [7:0]  tx3_data;
    int          checks = 0, passed = 0, tx_pulses = 0;

    always #5 clk = ~clk;
    always @(negedge clk) if (tx_valid[0] === 1'b1) tx_pulses++;

    qbus_slave_periph #(.RPLY_WAIT(0), .TTY_NUM(2), .TX_DELAY(40)) dut (
        .clk(clk), .rst(rst), .sync_n(sync_n), .din_n(din_n), .dout_n(dout_n),
        .wtbt_n(wtbt_n), .iako_n(iako_n), .ad_in_n(ad_in_n), .ad_out_n(ad_out_n),
        .ad_oe(ad_oe), .rply_n(rply_n), .virq_n(virq_n), .rx_valid(rx_valid),
        .rx_data(rx_data), .tx_valid(tx_valid), .tx_data(tx_data));

    qbus_slave_periph #(.RPLY_WAIT(3)) dut3 (
        .clk(clk), .rst(rst), .sync_n(sync3_n), .din_n(din3_n), .dout_n(dout_n),
        .wtbt_n(wtbt_n), .iako_n(1'b1), .ad_in_n(ad_in_n), .ad_out_n(ad3_out_n),
        .ad_oe(ad3_oe), .rply_n(rply3_n), .virq_n(virq3_n), .rx_valid(1'b0),
        .rx_data(8'h00), .tx_valid(tx3_valid), .tx_data(tx3_data));

    task automatic drive_sync(input int sel, input logic v);
        if (sel != 0) sync3_n = v; else sync_n = v;
    endtask

    task automatic drive_din(input int sel, input logic v);
        if (sel != 0) din3_n = v; else din_n = v;
    endtask

    task automatic wait_rply(input int sel, input int bound, output int lat);
        lat = 0;
        repeat (bound) begin
            @(negedge clk);
            lat++;
            if (!((sel != 0) ? rply3_n : rply_n)) return;
        end
        lat = -1;
    endtask

    task automatic bus_write(input int sel, input logic [15:0] a, input logic [15:0] d,
                             input logic bytew, output int lat);
        @(negedge clk); ad_in_n = ~a; drive_sync(sel, 1'b0);
        @(negedge clk); ad_in_n = ~d; wtbt_n = ~bytew; dout_n = 1'b0;
        wait_rply(sel, 100, lat);
        dout_n = 1'b1;
        @(negedge clk); drive_sync(sel, 1'b1); wtbt_n = 1'b1; ad_in_n = 16'hFFFF;
    endtask

    task automatic bus_read(input int sel, input logic [15:0] a, input int bound,
                            output logic [15:0] d, output logic oe, output int lat);
        @(negedge clk); ad_in_n = ~a; drive_sync(sel, 1'b0);
        @(negedge clk); ad_in_n = 16'hFFFF; drive_din(sel, 1'b0);
        wait_rply(sel, bound, lat);
        d  = (sel != 0) ? ~ad3_out_n : ~ad_out_n;
        oe = (sel != 0) ? ad3_oe : ad_oe;
        drive_din(sel, 1'b1);
        @(negedge clk); drive_sync(sel, 1'b1);
    endtask

    task automatic iack(input int bound, output logic [15:0] v, output int lat);
        @(negedge clk); din_n = 1'b0; iako_n = 1'b0;
        wait_rply(0, bound, lat);
        v = ~ad_out_n;
        din_n = 1'b1; iako_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [15:0] d; logic oe; int lat;
        repeat (3) @(negedge clk);
        checks++; if (rply_n !== 1'b1) $display("FAIL rst_rply got %b want 1", rply_n); else passed++;
        checks++; if (virq_n !== 1'b1) $display("FAIL rst_virq got %b want 1", virq_n); else passed++;
        checks++; if (ad_oe !== 1'b0) $display("FAIL rst_oe got %b want 0", ad_oe); else passed++;
        checks++; if (ad_out_n !== 16'hFFFF) $display("FAIL rst_ad got %h want ffff", ad_out_n); else passed++;
        checks++; if (tx_valid !== 2'b00 || tx_data !== 16'h0000)
            $display("FAIL rst_tx got %b/%h want 0/0", tx_valid, tx_data); else passed++;
        rst = 1'b0;
        bus_read(0, 16'o177564, 20, d, oe, lat);
        checks++; if (d !== 16'o000200) $display("FAIL rst_xcsr got %o want 200", d); else passed++;
        bus_read(0, 16'o177570, 20, d, oe, lat);
        checks++; if (d !== 16'o000000) $display("FAIL rst_rcsr1 got %o want 0", d); else passed++;
    endtask

    task automatic test_word_rw;
        logic [15:0] d; logic oe; int lat;
        bus_write(0, 16'o000100, 16'o123456, 1'b0, lat);
        checks++; if (lat !== 2) $display("FAIL wr_lat got %0d want 2", lat); else passed++;
        bus_read(0, 16'o000100, 100, d, oe, lat);
        checks++; if (d !== 16'o123456) $display("FAIL word_rd got %o want 123456", d); else passed++;
        checks++; if (lat !== 2 || oe !== 1'b1) $display("FAIL rd_lat got %0d/%b want 2/1", lat, oe); else passed++;
        bus_write(0, 16'o037776, 16'hBEEF, 1'b0, lat);
        bus_read(0, 16'o037776, 100, d, oe, lat);
        checks++; if (d !== 16'hBEEF) $display("FAIL ram_top got %h want beef", d); else passed++;
    endtask

    task automatic test_wait_states;
        logic [15:0] d; logic oe; int lat;
        bus_write(1, 16'o000200, 16'o052525, 1'b0, lat);
        checks++; if (lat !== 5) $display("FAIL ws_wr_lat got %0d want 5", lat); else passed++;
        bus_read(1, 16'o000200, 100, d, oe, lat);
        checks++; if (d !== 16'o052525 || lat !== 5)
            $display("FAIL ws_rd got %o lat %0d want 052525 lat 5", d, lat); else passed++;
    endtask

    task automatic test_byte_write;
        logic [15:0] d; logic oe; int lat;
        bus_write(0, 16'o000100, 16'o000000, 1'b0, lat);
        bus_write(0, 16'o000101, 16'o177400, 1'b1, lat);
        bus_read(0, 16'o000100, 100, d, oe, lat);
        checks++; if (d !== 16'o177400) $display("FAIL byte_hi got %o want 177400", d); else passed++;
        bus_write(0, 16'o000102, 16'h1234, 1'b0, lat);
        bus_write(0, 16'o000102, 16'h00AB, 1'b1, lat);
        bus_read(0, 16'o000102, 100, d, oe, lat);
        checks++; if (d !== 16'h12AB) $display("FAIL byte_lo got %h want 12ab", d); else passed++;
        bus_write(0, 16'o000103, 16'hCD00, 1'b1, lat);
        bus_read(0, 16'o000102, 100, d, oe, lat);
        checks++; if (d !== 16'hCDAB) $display("FAIL byte_hi2 got %h want cdab", d); else passed++;
    endtask

    task automatic test_timeout;
        logic [15:0] d; logic oe; int lat;
        bus_read(0, 16'o040000, 100, d, oe, lat);
        checks++; if (lat !== -1) $display("FAIL unmapped_reply got lat %0d want none", lat); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] d; logic oe; int lat;
        bus_write(0, 16'o000104, 16'h1111, 1'b0, lat);
        @(negedge clk); ad_in_n = ~16'o000104; sync_n = 1'b0;
        @(negedge clk); ad_in_n = 16'hFFFF; din_n = 1'b0;
        wait_rply(0, 100, lat);
        d = ~ad_out_n;
        din_n = 1'b1;
        @(negedge clk); ad_in_n = ~16'h2222; dout_n = 1'b0;
        wait_rply(0, 100, lat);
        dout_n = 1'b1;
        @(negedge clk); sync_n = 1'b1; ad_in_n = 16'hFFFF;
        checks++; if (d !== 16'h1111) $display("FAIL rmw_rd got %h want 1111", d); else passed++;
        checks++; if (lat !== 2) $display("FAIL rmw_wr_lat got %0d want 2", lat); else passed++;
        bus_read(0, 16'o000104, 100, d, oe, lat);
        checks++; if (d !== 16'h2222) $display("FAIL rmw_result got %h want 2222", d); else passed++;
    endtask

    task automatic test_tty_tx;
        logic [15:0] d; logic oe; int lat, waited;
        bus_write(0, 16'o177564, 16'o000100, 1'b0, lat);
        checks++; if (virq_n !== 1'b0) $display("FAIL ie_edge_irq got %b want 0", virq_n); else passed++;
        iack(20, d, lat);
        checks++; if (d !== 16'o000064 || lat !== 2)
            $display("FAIL ie_edge_vec got %o lat %0d want 064 lat 2", d, lat); else passed++;
        checks++; if (virq_n !== 1'b1) $display("FAIL ie_edge_clr got %b want 1", virq_n); else passed++;
        bus_write(0, 16'o177566, 16'o000101, 1'b0, lat);
        checks++; if (tx_pulses !== 1 || tx_data[7:0] !== 8'h41)
            $display("FAIL tx_out got %0d pulses data %h want 1/41", tx_pulses, tx_data[7:0]); else passed++;
        bus_read(0, 16'o177564, 20, d, oe, lat);
        checks++; if (d !== 16'o000100) $display("FAIL xcsr_busy got %o want 100", d); else passed++;
        checks++; if (virq_n !== 1'b1) $display("FAIL tx_busy_irq got %b want 1", virq_n); else passed++;
        waited = 0;
        while (virq_n === 1'b1 && waited < 200) begin @(negedge clk); waited++; end
        checks++; if (virq_n !== 1'b0 || waited < 20)
            $display("FAIL tx_done_irq got virq %b after %0d want 0 after >=20", virq_n, waited); else passed++;
        iack(20, d, lat);
        checks++; if (d !== 16'o000064) $display("FAIL tx_vec got %o want 064", d); else passed++;
        checks++; if (virq_n !== 1'b1) $display("FAIL tx_ack got %b want 1", virq_n); else passed++;
        bus_read(0, 16'o177564, 20, d, oe, lat);
        checks++; if (d !== 16'o000300) $display("FAIL xcsr_ready got %o want 300", d); else passed++;
    endtask

    task automatic test_rx_irq;
        logic [15:0] d; logic oe; int lat;
        bus_write(0, 16'o177560, 16'o000100, 1'b0, lat);
        bus_write(0, 16'o177570, 16'o000100, 1'b0, lat);
        checks++; if (virq_n !== 1'b1) $display("FAIL rx_idle_irq got %b want 1", virq_n); else passed++;
        @(negedge clk); rx_valid = 2'b11; rx_data = 16'hAA55;
        @(negedge clk); rx_valid = 2'b00;
        repeat (3) @(negedge clk);
        checks++; if (virq_n !== 1'b0) $display("FAIL rx_irq got %b want 0", virq_n); else passed++;
        bus_read(0, 16'o177560, 20, d, oe, lat);
        checks++; if (d !== 16'o000300) $display("FAIL rcsr0 got %o want 300", d); else passed++;
        iack(20, d, lat);
        checks++; if (d !== 16'o000060) $display("FAIL vec_ch0 got %o want 060", d); else passed++;
        checks++; if (virq_n !== 1'b0) $display("FAIL ch1_pending got %b want 0", virq_n); else passed++;
        iack(20, d, lat);
        checks++; if (d !== 16'o000070) $display("FAIL vec_ch1 got %o want 070", d); else passed++;
        checks++; if (virq_n !== 1'b1) $display("FAIL all_acked got %b want 1", virq_n); else passed++;
        bus_read(0, 16'o177572, 20, d, oe, lat);
        checks++; if (d !== 16'h00AA) $display("FAIL rbuf1 got %h want 00aa", d); else passed++;
        bus_read(0, 16'o177570, 20, d, oe, lat);
        checks++; if (d !== 16'o000100) $display("FAIL rcsr1_clr got %o want 100", d); else passed++;
        iack(20, d, lat);
        checks++; if (lat !== -1) $display("FAIL empty_iack got lat %0d want none", lat); else passed++;
    endtask

    task automatic test_rbuf_collision;
        logic [15:0] d; logic oe; int lat;
        @(negedge clk); ad_in_n = ~16'o177562; sync_n = 1'b0;
        @(negedge clk); ad_in_n = 16'hFFFF; din_n = 1'b0;
        @(negedge clk); rx_valid = 2'b01; rx_data = 16'h0077;
        @(negedge clk); rx_valid = 2'b00;
        d = ~ad_out_n;
        checks++; if (rply_n !== 1'b0 || d !== 16'h0055)
            $display("FAIL coll_rd got rply %b data %h want 0/0055", rply_n, d); else passed++;
        din_n = 1'b1;
        @(negedge clk); sync_n = 1'b1;
        bus_read(0, 16'o177560, 20, d, oe, lat);
        checks++; if (d !== 16'o000300) $display("FAIL coll_done got %o want 300", d); else passed++;
        bus_read(0, 16'o177562, 20, d, oe, lat);
        checks++; if (d !== 16'h0077) $display("FAIL coll_byte got %h want 0077", d); else passed++;
        bus_read(0, 16'o177560, 20, d, oe, lat);
        checks++; if (d !== 16'o000100) $display("FAIL coll_clr got %o want 100", d); else passed++;
    endtask

    task automatic test_reset_mid;
        logic [15:0] d; logic oe; int lat;
        @(negedge clk); ad_in_n = ~16'o000100; sync_n = 1'b0;
        @(negedge clk); ad_in_n = 16'hFFFF; din_n = 1'b0;
        wait_rply(0, 100, lat);
        checks++; if (rply_n !== 1'b0) $display("FAIL pre_rst_rply got %b want 0", rply_n); else passed++;
        #1 rst = 1'b1;
        #1;
        checks++; if (rply_n !== 1'b1 || ad_oe !== 1'b0)
            $display("FAIL mid_rst got rply %b oe %b want 1/0", rply_n, ad_oe); else passed++;
        sync_n = 1'b1; din_n = 1'b1;
        @(negedge clk); rst = 1'b0;
        bus_read(0, 16'o000100, 100, d, oe, lat);
        checks++; if (d !== 16'o177400 || lat !== 2)
            $display("FAIL post_rst_rd got %o lat %0d want 177400 lat 2", d, lat); else passed++;
        bus_read(0, 16'o177560, 20, d, oe, lat);
        checks++; if (d !== 16'o000000) $display("FAIL post_rst_rcsr got %o want 0", d); else passed++;
    endtask

    initial begin
        test_reset;
        test_word_rw;
        test_wait_states;
        test_byte_write;
        test_timeout;
        test_back_to_back;
        test_tty_tx;
        test_rx_irq;
        test_rbuf_collision;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
